// File: rtl/fetch_queue.sv
// Instruction fetch unit: PC generation, req/gnt/rvalid imem interface, in-order
// {pc_n, inst} queue toward decode. Define FETCH_BYPASS_EN for same-cycle forwarding.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isjmp,
    input  logic [31:0] pc_jmp,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc_n,
    input  logic        out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [CW:0]   DEPTH_C   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
    localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUT - 1);

    logic [31:0]   pc;
    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc_n [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic [31:0]   tag_mem [MAX_OUT];
    logic [TW-1:0] tag_rd;
    logic [TW-1:0] tag_wr;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic          accept;
    logic          resp_live;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          q_valid;
    logic [31:0]   tag_pc_n;
    logic [CW-1:0] outstanding_next;
    logic [CW:0]   reserved;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TAG_LAST) ? '0 : p + TW'(1);
    endfunction

    // Slots are reserved at issue time, so every live response always finds room.
    assign reserved  = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = rst_n && !isjmp && (outstanding < MAX_OUT_C) && (reserved < DEPTH_C);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;

    assign q_valid   = (count != '0);
    assign resp_live = imem_rvalid && (discard == '0) && !isjmp;
    assign tag_pc_n  = tag_mem[tag_rd] + 32'd4;

`ifdef FETCH_BYPASS_EN
    assign bypass = !q_valid && resp_live && out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = resp_live && !bypass;
    assign pop  = q_valid && out_ready && !isjmp;

    assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rvalid);

    always_comb begin
        out_valid = q_valid || bypass;
        out_inst  = '0;
        out_pc_n  = '0;
        if (bypass) begin
            out_inst = imem_rdata;
            out_pc_n = tag_pc_n;
        end else if (q_valid) begin
            out_inst = q_inst[head];
            out_pc_n = q_pc_n[head];
        end
    end

    // NOTE: sequential state is written only with <= so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            tag_rd      <= '0;
            tag_wr      <= '0;
        end else begin
            if (isjmp) begin
                pc <= {pc_jmp[31:2], 2'b00};
            end else if (accept) begin
                pc <= pc + 32'd4;
            end

            outstanding <= outstanding_next;

            // Every request still in flight after a redirect belongs to the old stream.
            if (isjmp) begin
                discard <= outstanding_next;
            end else if (imem_rvalid && (discard != '0)) begin
                discard <= discard - CW'(1);
            end

            if (accept) begin
                tag_wr <= tag_inc(tag_wr);
            end
            if (imem_rvalid) begin
                tag_rd <= tag_inc(tag_rd);
            end

            if (isjmp) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + AW'(1);
                end
                if (pop) begin
                    head <= head + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: storage arrays carry no reset; the outputs are gated by count so stale words never leak.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail] <= imem_rdata;
            q_pc_n[tail] <= tag_pc_n;
        end
        if (accept) begin
            tag_mem[tag_wr] <= pc;
        end
    end

    a_no_stray_response: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic compared
// against an epoch-based reference model of the fetch stream.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        isjmp;
    logic [31:0] pc_jmp;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc_n;
    logic        out_ready;

    fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .isjmp(isjmp), .pc_jmp(pc_jmp),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc_n(out_pc_n),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc_n;
        logic [31:0] inst;
    } ent_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          epoch  = 0;
    int          lat    = 1;
    bit          mem_hold = 1'b0;
    bit          ovr_en   = 1'b0;
    logic [31:0] ovr_data = 32'h0;
    logic [31:0] model_pc = RESET_PC;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] acc_log[$];
    logic [31:0] out_log[$];

    logic        obs_req;
    logic        obs_valid;
    logic [31:0] obs_pc_n;
    logic [31:0] obs_inst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0; isjmp = 1'b0; pc_jmp = '0; imem_gnt = 1'b1;
            imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b1;
            #1;
            check("rst_imem_req", 32'(imem_req), 32'd0);
            if (i > 0) begin
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_out_pc_n", out_pc_n, 32'd0);
                check("rst_out_inst", out_inst, 32'd0);
                check("rst_imem_addr", imem_addr, RESET_PC);
            end
            @(posedge clk);
            cyc++;
        end
        pend.delete();
        mq.delete();
        model_pc = RESET_PC;
        epoch++;
    endtask

    // One clock of stimulus; the model says what decode and imem must see, then advances.
    task automatic cycle(input logic jmp, input logic [31:0] tgt, input logic g, input logic rdy);
        logic        rv, live, byp, exp_req, exp_valid, acc;
        logic [31:0] acc_addr;
        ent_t        hd;
        req_t        r;
        @(negedge clk);
        rst_n = 1'b1; isjmp = jmp; pc_jmp = tgt; imem_gnt = g; out_ready = rdy;
        rv = (pend.size() > 0) && !mem_hold && (cyc >= pend[0].due);
        imem_rvalid = rv;
        imem_rdata  = rv ? pend[0].data : $urandom;
        #1;
        exp_req = !jmp && (pend.size() < MAX_OUT) && ((mq.size() + pend.size()) < DEPTH);
        live = 1'b0;
        if (rv) live = (pend[0].epoch == epoch) && !jmp;
        byp = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp = live && (mq.size() == 0) && rdy;
`endif
        exp_valid = (mq.size() != 0) || byp;
        hd = '{32'h0, 32'h0};
        if (byp) hd = '{pend[0].addr + 32'd4, pend[0].data};
        else if (mq.size() != 0) hd = mq[0];

        check("imem_req", 32'(imem_req), 32'(exp_req));
        check("imem_addr", imem_addr, model_pc);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("out_pc_n", out_pc_n, hd.pc_n);
            check("out_inst", out_inst, hd.inst);
        end
        obs_req = imem_req; obs_valid = out_valid; obs_pc_n = out_pc_n; obs_inst = out_inst;
        acc = imem_req && g;
        acc_addr = imem_addr;

        @(posedge clk);
        if (rv) r = pend.pop_front();
        if (acc) begin
            pend.push_back('{acc_addr, ovr_en ? ovr_data : (acc_addr ^ 32'hA5A5_0000), epoch, cyc + lat});
            acc_log.push_back(acc_addr);
        end
        cyc++;
        if (exp_valid && rdy && !jmp) begin
            out_log.push_back(hd.pc_n);
            if (!byp) void'(mq.pop_front());
        end
        if (live && !byp) mq.push_back('{r.addr + 32'd4, r.data});
        if (jmp) begin
            mq.delete();
            epoch++;
            model_pc = {tgt[31:2], 2'b00};
        end else if (exp_req && g) begin
            model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic redirect_clean(input logic [31:0] tgt);
        mem_hold = 1'b0;
        repeat (8) cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, tgt, 1'b0, 1'b1);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        out_log.delete();
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; isjmp = 1'b0; pc_jmp = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;

        do_reset(3);

        // Straight-line fetch with one-cycle memory latency.
        clear_logs();
        lat = 1;
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n0 = out_log.size();
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("steady_rate", 32'(out_log.size() - n0), 32'd10);
        check("first_addr", acc_log[0], 32'h0);
        check("stream_0", out_log[0], 32'h4);
        check("stream_1", out_log[1], 32'h8);
        check("stream_2", out_log[2], 32'hC);

        // Backpressure fills exactly DEPTH entries.
        redirect_clean(32'h0);
        clear_logs();
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("bp_accepts", 32'(acc_log.size()), 32'd4);
        check("bp_req_low", 32'(obs_req), 32'd0);
        check("bp_valid_high", 32'(obs_valid), 32'd1);
        repeat (12) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("bp_pop_0", out_log[0], 32'h4);
        check("bp_pop_1", out_log[1], 32'h8);
        check("bp_pop_2", out_log[2], 32'hC);
        check("bp_pop_3", out_log[3], 32'h10);
        check("bp_resume", acc_log[4], 32'h10);

        // Redirect with two requests in flight.
        redirect_clean(32'h8);
        clear_logs();
        mem_hold = 1'b1;
        repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("inflight_0", acc_log[0], 32'h8);
        check("inflight_1", acc_log[1], 32'hC);
        check("inflight_cnt", 32'(acc_log.size()), 32'd2);
        cycle(1'b1, 32'h100, 1'b1, 1'b1);
        check("jmp_req_low", 32'(obs_req), 32'd0);
        mem_hold = 1'b0;
        clear_logs();
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("jmp_addr", acc_log[0], 32'h100);
        check("jmp_first_out", out_log[0], 32'h104);

        // Redirect coinciding with a response and a fresh accept in the previous cycle.
        repeat (6) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        clear_logs();
        cycle(1'b1, 32'h303, 1'b1, 1'b1);
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check("sim_addr", acc_log[0], 32'h300);
        check("sim_first_out", out_log[0], 32'h304);

        // Empty-queue response: same-cycle forward or one-cycle registered latency.
        redirect_clean(32'h20);
        mem_hold = 1'b1;
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        ovr_en   = 1'b0;
        mem_hold = 1'b0;
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef FETCH_BYPASS_EN
        check("byp_valid", 32'(obs_valid), 32'd1);
        check("byp_pc_n", obs_pc_n, 32'h24);
        check("byp_inst", obs_inst, 32'hDEAD_BEEF);
`else
        check("nobyp_valid0", 32'(obs_valid), 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        check("nobyp_valid1", 32'(obs_valid), 32'd1);
        check("nobyp_pc_n", obs_pc_n, 32'h24);
        check("nobyp_inst", obs_inst, 32'hDEAD_BEEF);
`endif

        // Random traffic, including wrap-around targets and a mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] tgt;
            if (i == 700) begin
                do_reset(2);
            end else begin
                lat      = int'($urandom_range(1, 3));
                mem_hold = ($urandom % 4) == 0;
                tgt      = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
                cycle(($urandom % 16) == 0, tgt, ($urandom % 4) != 0, ($urandom % 3) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
